// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit width, header/tail encodings, port count,
// route state encoding and small flit-classification helpers.
package noc_pkg;

    localparam int               FLIT_W    = 8;
    localparam int               NUM_PORTS = 4;
    localparam logic [5:0]       HDR_TAG   = 6'b101111;
    localparam logic [7:0]       TAIL_FLIT = 8'hFF;

    // The NI builds its header as HEADER | dest and ends packets with TAILER.
    localparam logic [FLIT_W-1:0] HEADER = {HDR_TAG, 2'b00};
    localparam logic [FLIT_W-1:0] TAILER = TAIL_FLIT;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } route_state_e;

    function automatic logic is_hdr(input logic [FLIT_W-1:0] f);
        return (f[FLIT_W-1:2] == HDR_TAG);
    endfunction

    function automatic logic is_tail(input logic [FLIT_W-1:0] f);
        return (f == TAIL_FLIT);
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/noc_flit_router_if.sv
// Flit handshake bundle between the NI-side source, the router and its four
// output ports (shared flit bus, one-hot per-port valid/ready).
interface noc_flit_router_if;
    import noc_pkg::*;

    logic [FLIT_W-1:0]    in_flit;
    logic                 in_valid;
    logic                 in_ready;
    logic [FLIT_W-1:0]    out_flit;
    logic [NUM_PORTS-1:0] out_valid;
    logic [NUM_PORTS-1:0] out_ready;

    modport slave (
        input  in_flit,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_flit,
        output out_valid
    );

    modport master (
        output in_flit,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_flit,
        input  out_valid
    );

endinterface

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO; an extra pointer bit separates full from empty.
// Head is read straight from storage so a pushed flit shows up next cycle.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FLIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o   = (wr_q == rd_q);
    assign head_o    = mem_q[rd_q[AW-1:0]];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next-state pointers
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Flit storage write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/noc_flit_router.sv
// One-input, four-output flit router: buffers flits, locks a route on a header
// until the tail passes, drops stray flits and flags over-length packets.
module noc_flit_router
    import noc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_FLITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    noc_flit_router_if.slave        bus,
    output logic                    busy,
    output logic [7:0]              drop_cnt,
    output logic                    len_err
);

    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    route_state_e         state_q, state_d;
    logic [1:0]           dest_q, dest_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           drop_q, drop_d;
    logic                 len_q, len_d;

    logic                 full_s;
    logic                 empty_s;
    logic [FLIT_W-1:0]    head_s;
    logic                 pop_s;
    logic [NUM_PORTS-1:0] out_valid_s;

    noc_flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.in_valid),
        .pop_i   (pop_s),
        .data_i  (bus.in_flit),
        .full_o  (full_s),
        .empty_o (empty_s),
        .head_o  (head_s)
    );

    assign bus.in_ready  = !full_s;
    assign bus.out_flit  = head_s;
    assign bus.out_valid = out_valid_s;
    assign busy          = (state_q == ST_FWD);
    assign drop_cnt      = drop_q;
    assign len_err       = len_q;

    // Route decision for the flit at the FIFO head
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        len_d       = len_q;
        pop_s       = 1'b0;
        out_valid_s = '0;
        if (!empty_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_hdr(head_s)) begin
                        out_valid_s = port_onehot(head_s[1:0]);
                        if (bus.out_ready[head_s[1:0]]) begin
                            pop_s   = 1'b1;
                            dest_d  = head_s[1:0];
                            cnt_d   = CNT_W'(1);
                            state_d = ST_FWD;
                        end else begin
                            pop_s   = 1'b0;
                        end
                    end else begin
                        // Stray flit outside a packet: discard and count it
                        pop_s = 1'b1;
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end else begin
                            drop_d = drop_q;
                        end
                    end
                end
                ST_FWD: begin
                    out_valid_s = port_onehot(dest_q);
                    if (bus.out_ready[dest_q]) begin
                        pop_s = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (is_tail(head_s)) begin
                            state_d = ST_IDLE;
                        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_FLITS)) begin
                            len_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FWD;
                        end
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Route state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dest_q  <= 2'd0;
            cnt_q   <= '0;
            drop_q  <= 8'd0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_router.sv
// Self-checking bench for noc_flit_router: queue-based packet model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_noc_flit_router;
    import noc_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MAX_FLITS = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       len_err;

    noc_flit_router_if bus();

    noc_flit_router #(.DEPTH(DEPTH), .MAX_FLITS(MAX_FLITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: buffered flits plus "inside a packet" bookkeeping
    logic [7:0] mq[$];
    bit         m_in_pkt;
    int         m_dest;
    int         m_len;
    int         m_drop;
    bit         m_len_err;
    bit         model_ok = 1'b0;
    logic [7:0] dq_flit[$];
    int         dq_port[$];
    bit         rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model past the edge
    always @(negedge clk) begin
        logic [3:0] exp_ov;
        logic [7:0] h;
        bit         do_pop;
        bit         do_push;
        if (!rst_n) begin
            mq.delete();
            m_in_pkt  = 1'b0;
            m_dest    = 0;
            m_len     = 0;
            m_drop    = 0;
            m_len_err = 1'b0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            exp_ov = 4'b0000;
            h      = 8'h00;
            if (mq.size() > 0) begin
                h = mq[0];
                if (m_in_pkt) exp_ov[m_dest] = 1'b1;
                else if (h[7:2] == 6'b101111) exp_ov[h[1:0]] = 1'b1;
            end
            chk("in_ready", bus.in_ready, (mq.size() < DEPTH) ? 1 : 0);
            chk("out_valid", bus.out_valid, exp_ov);
            if (mq.size() > 0) chk("out_flit", bus.out_flit, h);
            chk("busy", busy, m_in_pkt);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("len_err", len_err, m_len_err);

            do_push = bus.in_valid && (mq.size() < DEPTH);
            do_pop  = 1'b0;
            if (mq.size() > 0) begin
                if (exp_ov == 4'b0000) begin
                    do_pop = 1'b1;
                    if (m_drop < 255) m_drop++;
                end else if ((exp_ov & bus.out_ready) != 4'b0000) begin
                    do_pop = 1'b1;
                    dq_flit.push_back(h);
                    if (!m_in_pkt) begin
                        m_in_pkt = 1'b1;
                        m_dest   = h[1:0];
                        m_len    = 1;
                    end else begin
                        m_len++;
                        if (h == 8'hFF) m_in_pkt = 1'b0;
                        else if (m_len == MAX_FLITS) begin
                            m_in_pkt  = 1'b0;
                            m_len_err = 1'b1;
                        end
                    end
                    dq_port.push_back(m_in_pkt ? m_dest : int'(h == 8'hFF ? m_dest : m_dest));
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(bus.in_flit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] f);
        bit acc;
        int n;
        bus.in_flit  = f;
        bus.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dq_flit.delete();
        dq_port.delete();
    endtask

    // Compare the model's delivery log with a hand-written sequence (first flit in MSBs)
    task automatic chk_seq(input string name, input int n, input logic [63:0] flits,
                           input logic [15:0] ports);
        chk({name, "_count"}, dq_flit.size(), n);
        for (int k = 0; k < n && k < dq_flit.size(); k++) begin
            chk({name, "_flit"}, dq_flit[k], flits[8*(n-1-k) +: 8]);
            chk({name, "_port"}, dq_port[k], ports[2*(n-1-k) +: 2]);
        end
    endtask

    initial begin
        bus.in_flit   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_len_err", len_err, 0);

        // Basic route to port 2
        send(8'hBE); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'hFF);
        idle(6);
        chk_seq("basic", 6, 64'hBE11223344FF, 16'b10_10_10_10_10_10);
        chk("basic_drop", drop_cnt, 0);

        // Short packet followed immediately by another
        do_reset();
        send(8'hBD); send(8'h55); send(8'hFF); send(8'hBC); send(8'h66); send(8'hFF);
        idle(6);
        chk_seq("b2b", 6, 64'hBD55FFBC66FF, 16'b01_01_01_00_00_00);

        // Backpressure until full, then release port 3
        do_reset();
        bus.out_ready = 4'h0;
        send(8'hBF); send(8'h01); send(8'h02); send(8'h03);
        chk("full_in_ready", bus.in_ready, 0);
        fork
            send(8'h04);
            begin
                repeat (5) @(posedge clk);
                #2 bus.out_ready = 4'b1000;
            end
        join
        idle(8);
        chk_seq("bp", 5, 64'hBF01020304, 16'b11_11_11_11_11);
        chk("bp_in_ready", bus.in_ready, 1);
        bus.out_ready = 4'hF;

        // Stray flits dropped in IDLE
        do_reset();
        send(8'h12); send(8'h34); send(8'hBE); send(8'hFF);
        idle(6);
        chk("drop_cnt2", drop_cnt, 2);
        chk_seq("drop", 2, 64'hBEFF, 16'b10_10);

        // Over-length packet
        do_reset();
        send(8'hBC); send(8'h01); send(8'h02); send(8'h03);
        send(8'h04); send(8'h05); send(8'h06); send(8'hFF);
        idle(6);
        chk("len_err_set", len_err, 1);
        chk("len_drop", drop_cnt, 2);
        chk_seq("len", 6, 64'hBC0102030405, 16'b00_00_00_00_00_00);

        // Reset in the middle of a packet
        do_reset();
        send(8'hBE); send(8'h11);
        do_reset();
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", bus.out_valid, 0);
        chk("mid_drop", drop_cnt, 0);
        chk("mid_in_ready", bus.in_ready, 1);
        send(8'hBD); send(8'h77); send(8'hFF);
        idle(6);
        chk_seq("mid", 3, 64'hBD77FF, 16'b01_01_01);

        // Random traffic with random per-port ready
        do_reset();
        rand_ready = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int kind;
            int nb;
            logic [7:0] b;
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                send(8'($urandom_range(0, 255)));
            end else begin
                send({6'b101111, 2'($urandom_range(0, 3))});
                nb = $urandom_range(0, 5);
                for (int k = 0; k < nb; k++) begin
                    b = 8'($urandom_range(0, 254));
                    send(b);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                send(8'hFF);
            end
        end
        rand_ready = 1'b0;
        bus.out_ready = 4'hF;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
